// File: rtl/result_frame_emitter.sv
// Accumulates signed samples into frames and emits a 64-bit sum plus a saturated 32-bit copy per frame.
// Optional RESULT_AVG_EN: adds avg_shift, and result_32 becomes saturate32(sum >>> avg_shift).
module result_frame_emitter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     reset_from_control,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_valid,
    input  logic [CNT_W-1:0]         frame_len,
    input  logic [CNT_W-1:0]         num_results,
`ifdef RESULT_AVG_EN
    input  logic [5:0]               avg_shift,
`endif
    output logic signed [63:0]       result_64,
    output logic                     result_64_valid,
    output logic signed [31:0]       result_32,
    output logic                     result_32_valid,
    output logic                     calculo_finalizado,
    output logic [CNT_W-1:0]         results_emitted,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic signed [63:0] MAX32 = 64'sd2147483647;
    localparam logic signed [63:0] MIN32 = -64'sd2147483648;

    state_t             state_q;
    logic signed [63:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   fl_q;
    logic [CNT_W-1:0]   nr_q;
    logic [CNT_W-1:0]   emitted_q;
    logic signed [63:0] res64_q;
    logic signed [31:0] res32_q;
    logic               valid_q;
    logic               fin_q;
`ifdef RESULT_AVG_EN
    logic [5:0]         shift_q;
`endif

    logic signed [63:0] sample_ext;
    logic signed [63:0] sum_d;
    logic signed [63:0] scaled_d;
    logic signed [31:0] sat32_d;
    logic [CNT_W-1:0]   emitted_d;
    logic               last_sample;

    assign sample_ext = {{(64-DATA_W){data_in[DATA_W-1]}}, data_in};
    // Frame sum includes the sample being captured now, so the closing edge can publish it directly.
    assign sum_d      = acc_q + sample_ext;
`ifdef RESULT_AVG_EN
    assign scaled_d   = sum_d >>> shift_q;
`else
    assign scaled_d   = sum_d;
`endif
    assign emitted_d   = emitted_q + CNT_W'(1);
    assign last_sample = (cnt_q == fl_q - CNT_W'(1));

    always_comb begin
        sat32_d = scaled_d[31:0];
        if (scaled_d > MAX32) begin
            sat32_d = 32'sh7FFF_FFFF;
        end else if (scaled_d < MIN32) begin
            sat32_d = 32'sh8000_0000;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            fl_q      <= '0;
            nr_q      <= '0;
            emitted_q <= '0;
            res64_q   <= '0;
            res32_q   <= '0;
            valid_q   <= 1'b0;
            fin_q     <= 1'b0;
`ifdef RESULT_AVG_EN
            shift_q   <= '0;
`endif
        end else if (reset_from_control) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            fl_q      <= '0;
            nr_q      <= '0;
            emitted_q <= '0;
            res64_q   <= '0;
            res32_q   <= '0;
            valid_q   <= 1'b0;
            fin_q     <= 1'b0;
`ifdef RESULT_AVG_EN
            shift_q   <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable && frame_len != '0 && num_results != '0) begin
                        state_q   <= S_ACCUM;
                        fl_q      <= frame_len;
                        nr_q      <= num_results;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        emitted_q <= '0;
`ifdef RESULT_AVG_EN
                        shift_q   <= avg_shift;
`endif
                    end
                end
                S_ACCUM: begin
                    if (enable && data_valid) begin
                        if (last_sample) begin
                            res64_q   <= sum_d;
                            res32_q   <= sat32_d;
                            valid_q   <= 1'b1;
                            emitted_q <= emitted_d;
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            if (emitted_d == nr_q) begin
                                state_q <= S_DONE;
                                fin_q   <= 1'b1;
                            end
                        end else begin
                            acc_q <= sum_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Dropping enable is the handshake that acknowledges the finished run.
                    if (!enable) begin
                        state_q   <= S_IDLE;
                        fin_q     <= 1'b0;
                        emitted_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result_64          = res64_q;
    assign result_64_valid    = valid_q;
    assign result_32          = res32_q;
    assign result_32_valid    = valid_q;
    assign calculo_finalizado = fin_q;
    assign results_emitted    = emitted_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_result_frame_emitter.sv
// Randomized and directed bench for result_frame_emitter against a frame-level reference model.
module tb_result_frame_emitter;

  localparam int DW = 20;

  logic                 clk;
  logic                 reset_n;
  logic                 reset_from_control;
  logic                 enable;
  logic signed [DW-1:0] data_in;
  logic                 data_valid;
  logic [31:0]          frame_len;
  logic [31:0]          num_results;
  logic signed [63:0]   result_64;
  logic                 result_64_valid;
  logic signed [31:0]   result_32;
  logic                 result_32_valid;
  logic                 calculo_finalizado;
  logic [31:0]          results_emitted;
  logic [1:0]           state_dbg;
`ifdef RESULT_AVG_EN
  logic [5:0]           avg_shift;
`endif

  result_frame_emitter #(.DATA_W(DW), .CNT_W(32)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .reset_from_control (reset_from_control),
    .enable             (enable),
    .data_in            (data_in),
    .data_valid         (data_valid),
    .frame_len          (frame_len),
    .num_results        (num_results),
`ifdef RESULT_AVG_EN
    .avg_shift          (avg_shift),
`endif
    .result_64          (result_64),
    .result_64_valid    (result_64_valid),
    .result_32          (result_32),
    .result_32_valid    (result_32_valid),
    .calculo_finalizado (calculo_finalizado),
    .results_emitted    (results_emitted),
    .state_dbg          (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // reference model: a run collects accepted samples; a full frame becomes one expected result
  logic   m_running, m_done;
  int     m_fl, m_nr, m_shift, m_emitted;
  int     frame_q[$];
  longint m_r64, m_r32;
  logic   m_valid;
  longint exp_q[$];

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic void model_reset();
    m_running = 0; m_done = 0; m_fl = 0; m_nr = 0; m_shift = 0; m_emitted = 0;
    frame_q.delete(); exp_q.delete();
    m_r64 = 0; m_r32 = 0; m_valid = 0;
  endfunction

  function automatic void model_step(input logic en, input logic dv, input int d, input logic rfc);
    longint s;
    m_valid = 0;
    if (rfc) begin
      model_reset();
      return;
    end
    if (m_done) begin
      if (!en) begin m_done = 0; m_emitted = 0; end
    end else if (m_running) begin
      if (en && dv) begin
        frame_q.push_back(d);
        if (frame_q.size() == m_fl) begin
          s = 0;
          foreach (frame_q[i]) s += longint'(frame_q[i]);
          frame_q.delete();
          m_r64 = s;
          m_r32 = sat32(s >>> m_shift);
          m_valid = 1;
          exp_q.push_back(s);
          m_emitted++;
          if (m_emitted == m_nr) begin m_running = 0; m_done = 1; end
        end
      end
    end else if (en && frame_len != 0 && num_results != 0) begin
      m_running = 1; m_fl = frame_len; m_nr = num_results; m_emitted = 0;
`ifdef RESULT_AVG_EN
      m_shift = avg_shift;
`else
      m_shift = 0;
`endif
      frame_q.delete();
    end
  endfunction

  // scoreboard check of every output after each edge
  task automatic check_outputs();
    longint e;
    check("v64", result_64_valid, m_valid);
    check("v32", result_32_valid, m_valid);
    check("fin", calculo_finalizado, m_done);
    check("emitted", results_emitted, m_emitted);
    check("r64", result_64, m_r64);
    check("r32", longint'(result_32), m_r32);
    if (result_64_valid) begin
      if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sb_r64", result_64, e);
      end
    end
  endtask

  // driver
  task automatic step(input logic en, input logic dv, input int d, input logic rfc);
    enable = en; data_valid = dv; data_in = d[DW-1:0]; reset_from_control = rfc;
    model_step(en, dv, d, rfc);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic go_idle();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_r64"}, result_64, 0);
    check({tag, "_r32"}, result_32, 0);
    check({tag, "_v"}, {result_64_valid, result_32_valid}, 0);
    check({tag, "_fin"}, calculo_finalizado, 0);
    check({tag, "_cnt"}, results_emitted, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  int vals[$];
  int d;

  initial begin
    reset_n = 0; reset_from_control = 0; enable = 0; data_valid = 0; data_in = '0;
    frame_len = 0; num_results = 0;
`ifdef RESULT_AVG_EN
    avg_shift = 0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1;

    // basic run: 1..8 in frames of 4
    frame_len = 4; num_results = 2;
    step(1, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, 1, i, 0);
    check("basic_r64", result_64, 26);
    check("basic_cnt", results_emitted, 2);
    check("basic_fin", calculo_finalizado, 1);
    repeat (4) step(1, 1, 99, 0);
    go_idle();

    // saturation both directions
    frame_len = 4100; num_results = 1;
    step(1, 0, 0, 0);
    repeat (4100) step(1, 1, (1 << (DW-1)) - 1, 0);
    check("sat_pos_r32", result_32, 32'sh7FFF_FFFF);
    go_idle();
    step(1, 0, 0, 0);
    repeat (4100) step(1, 1, -(1 << (DW-1)), 0);
    check("sat_neg_r32", result_32, 32'sh8000_0000);
    go_idle();

    // pause mid-frame
    frame_len = 3; num_results = 1;
    step(1, 0, 0, 0);
    step(1, 1, 5, 0); step(1, 1, 5, 0);
    repeat (10) step(0, 1, 100, 0);
    step(1, 1, 5, 0);
    check("pause_r64", result_64, 15);
    go_idle();

    // sync reset mid-frame
    frame_len = 4; num_results = 1;
    step(1, 0, 0, 0);
    step(1, 1, 7, 0); step(1, 1, 7, 0);
    step(1, 1, 7, 1);
    check_zero("rfc");
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
    check("post_rfc_r64", result_64, 4);
    go_idle();

    // async reset between edges
    step(1, 0, 0, 0);
    step(1, 1, 9, 0); step(1, 1, 9, 0);
    #2 reset_n = 0;
    #1;
    model_reset();
    check_zero("async");
    @(posedge clk);
    #1 reset_n = 1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 2, 0);
    check("post_async_r64", result_64, 8);
    go_idle();

    // zero config then back-to-back frames of 1
    frame_len = 0; num_results = 3;
    repeat (5) step(1, 1, 3, 0);
    check("zero_state", state_dbg, 0);
    frame_len = 1;
    step(1, 0, 0, 0);
    vals = '{-1, 2, -3};
    foreach (vals[i]) step(1, 1, vals[i], 0);
    check("b2b_fin", calculo_finalizado, 1);
    step(1, 1, 4, 0);
    go_idle();

`ifdef RESULT_AVG_EN
    frame_len = 8; num_results = 2; avg_shift = 3;
    step(1, 0, 0, 0);
    repeat (8) step(1, 1, -9, 0);
    check("avg_r32_a", result_32, -32'sd9);
    repeat (7) step(1, 1, -9, 0);
    step(1, 1, -10, 0);
    check("avg_r32_b", result_32, -32'sd10);
    go_idle();
    avg_shift = 0;
`endif

    // randomized traffic, including config changes mid-run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 40) == 0) frame_len = $urandom_range(0, 6);
      if ($urandom_range(0, 40) == 0) num_results = $urandom_range(0, 4);
`ifdef RESULT_AVG_EN
      if ($urandom_range(0, 40) == 0) avg_shift = 6'($urandom_range(0, 63));
`endif
      d = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW-1));
      step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 70, d, $urandom_range(0, 199) == 0);
    end
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
